sprite_compositor: RTL and testbench
====================================

SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 Parameter NUM_SPRITES, default 4, meaning number of sprite layers; index 0 is the player; priority falls with rising index.
REQ-002 Parameter COORD_W, default 10, meaning width of every coordinate and size field.
REQ-003 Parameter ADDR_W, default 14, meaning width of each per-sprite ROM address.
REQ-004 Parameter KEY_RGB, default 24'h800080, meaning the transparent colour key.
REQ-005 Parameter HIT_REACH, default 20, meaning horizontal attack offset from the player centre.
REQ-006 Parameter BG_RGB, default 24'h3F007F, meaning background colour when COMPOSITOR_GRADIENT_EN is undefined.
REQ-007 Clk  in  1  the single clock; all state updates on the rising edge.
REQ-008 Reset  in  1  synchronous, active-high reset.
REQ-009 DrawX, DrawY  in  COORD_W each  current pixel coordinate.
REQ-010 spr_x, spr_y  in  NUM_SPRITES*COORD_W each  sprite centre positions, packed with sprite i at slice i.
REQ-011 spr_w, spr_h  in  NUM_SPRITES*COORD_W each  sprite width and height, packed.
REQ-012 spr_en  in  NUM_SPRITES  per-sprite visibility/activity enable.
REQ-013 rom_addr  out  NUM_SPRITES*ADDR_W  per-sprite pixel address into external synchronous ROM/palette, combinational from DrawX/DrawY.
REQ-014 rom_rgb  in  NUM_SPRITES*24  palette colour returned exactly 1 cycle after rom_addr.
REQ-015 facing_left, attack  in  1 each  player state.
REQ-016 clear_kill  in  NUM_SPRITES  per-sprite kill-flag clear; bit 0 is ignored.
REQ-017 VGA_R, VGA_G, VGA_B  out  8 each  registered pixel colour.
REQ-018 killed  out  NUM_SPRITES  sticky per-sprite kill flags; bit 0 is always 0.
REQ-019 death_x, death_y  out  COORD_W each  position of the most recently killed sprite.

Function
REQ-020 Box test: sprite i covers the pixel when DrawX is in [x-w/2, x+w/2) and DrawY is in [y-h/2, y+h/2), evaluated signed at COORD_W+1 bits so edges below 0 do not wrap.
REQ-021 rom_addr slice i = (DrawY-top)*w + (DrawX-left), truncated to ADDR_W; the value outside the box is don't-care.
REQ-022 Stage 1 (cycle N) registers the per-sprite box hit, the spr_en bit and DrawX[9:3].
REQ-023 Stage 2 (cycle N+1) treats sprite i as opaque when its stage-1 hit is 1, rom_rgb slice i != KEY_RGB, and it is not (killed[i] and i>0); the lowest-index opaque sprite wins; with no opaque sprite the background is used.
REQ-024 VGA outputs are registered at the end of stage 2: fixed latency 2 cycles from DrawX/DrawY to VGA_R/G/B.
REQ-025 Hit point: hx = x0+HIT_REACH when facing_left=0 and hx = x0-HIT_REACH when facing_left=1; hy = y0.
REQ-026 When attack=1, spr_en[0]=1, spr_en[i]=1, and (hx,hy) lies inside sprite i's box (REQ-020 bounds), killed[i] sets on the next edge for each i>=1.
REQ-027 When killed[i] rises, death_x/death_y capture spr_x/spr_y of sprite i; if several sprites rise in the same cycle, the lowest index is captured.
REQ-028 clear_kill[i] clears killed[i] on the next edge; a simultaneous set and clear resolves to set.
REQ-029 killed[i] holds while spr_en[i]=0; visibility is still masked by REQ-023.

Reset
REQ-030 When Reset=1 at an edge, killed=0, death_x=0, death_y=0, VGA_R/G/B=0 and all pipeline registers are cleared.
REQ-031 Reset asserted mid-frame blanks the output for 2 cycles after deassertion, then output resumes at normal latency.

Configuration
REQ-032 Macro COMPOSITOR_GRADIENT_EN, when defined, makes the background {8'h3F, 8'h00, 8'h7F - {1'b0, DrawX[9:3]}}, using the stage-1 delayed DrawX.
REQ-033 When COMPOSITOR_GRADIENT_EN is undefined, the background is the constant BG_RGB and no DrawX pipeline register exists.

Verification
REQ-034 Bench: sprite0 at (100,100) 40x60, rom_rgb0=24'hFF0000, pixel (100,100) -> VGA={FF,00,00} exactly 2 cycles later.
REQ-035 Bench: sprites 0 and 1 overlap at pixel, rom_rgb0=KEY_RGB, rom_rgb1=24'h00FF00 -> output 00FF00; with rom_rgb0=24'h0000FF -> output 0000FF.
REQ-036 Bench: player (200,100) facing right, sprite1 (220,100) 30x64, attack=1 for 1 cycle -> killed[1]=1 next cycle, death=(220,100), and sprite1 pixels then show background.
REQ-037 Bench: clear_kill[1] and a hit on sprite 1 in the same cycle -> killed[1] stays 1; clear alone -> 0 next cycle.
REQ-038 Bench: sprite at x=5, w=40, pixel DrawX=630 -> no hit (no wrap); pixel DrawX=0 -> hit.
REQ-039 Bench: gradient build, no sprite, DrawX=80 -> VGA={3F,00,75}; non-gradient build -> BG_RGB.

Source files
------------

// File: rtl/sprite_compositor.sv
// rtl/sprite_compositor.sv - multi-layer sprite compositor with colour-key transparency and player attack kill tracking
// Optional background gradient: define COMPOSITOR_GRADIENT_EN.
module sprite_compositor #(
  parameter int          NUM_SPRITES = 4,
  parameter int          COORD_W     = 10,
  parameter int          ADDR_W      = 14,
  parameter logic [23:0] KEY_RGB     = 24'h800080,
  parameter int          HIT_REACH   = 20,
  parameter logic [23:0] BG_RGB      = 24'h3F007F
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [COORD_W-1:0]            DrawX,
  input  logic [COORD_W-1:0]            DrawY,
  input  logic [NUM_SPRITES*COORD_W-1:0] spr_x,
  input  logic [NUM_SPRITES*COORD_W-1:0] spr_y,
  input  logic [NUM_SPRITES*COORD_W-1:0] spr_w,
  input  logic [NUM_SPRITES*COORD_W-1:0] spr_h,
  input  logic [NUM_SPRITES-1:0]        spr_en,
  output logic [NUM_SPRITES*ADDR_W-1:0] rom_addr,
  input  logic [NUM_SPRITES*24-1:0]     rom_rgb,
  input  logic                          facing_left,
  input  logic                          attack,
  input  logic [NUM_SPRITES-1:0]        clear_kill,
  output logic [7:0]                    VGA_R,
  output logic [7:0]                    VGA_G,
  output logic [7:0]                    VGA_B,
  output logic [NUM_SPRITES-1:0]        killed,
  output logic [COORD_W-1:0]            death_x,
  output logic [COORD_W-1:0]            death_y
);

  localparam int SW = COORD_W + 1;
  localparam logic signed [SW-1:0] REACH = SW'(HIT_REACH);

  logic signed [SW-1:0]   px, py, hx, hy;
  logic [NUM_SPRITES-1:0] pix_hit, kill_set, rise, opaque;
  logic [NUM_SPRITES-1:0] hit_s1, en_s1;
  logic                   valid_s1;
  logic [23:0]            bg_rgb, pix_rgb;
  logic [COORD_W-1:0]     cap_x, cap_y;
  logic                   cap_en;

  // Coordinates go one bit wider and signed so box edges left of / above 0 stay negative.
  assign px = $signed({1'b0, DrawX});
  assign py = $signed({1'b0, DrawY});
  assign hx = facing_left ? $signed({1'b0, spr_x[COORD_W-1:0]}) - REACH
                          : $signed({1'b0, spr_x[COORD_W-1:0]}) + REACH;
  assign hy = $signed({1'b0, spr_y[COORD_W-1:0]});

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_spr
    logic [COORD_W-1:0]   w, h;
    logic signed [SW-1:0] cx, cy, left, right, top, bottom;
    logic [SW-1:0]        rel_x, rel_y;

    assign w      = spr_w[i*COORD_W +: COORD_W];
    assign h      = spr_h[i*COORD_W +: COORD_W];
    assign cx     = $signed({1'b0, spr_x[i*COORD_W +: COORD_W]});
    assign cy     = $signed({1'b0, spr_y[i*COORD_W +: COORD_W]});
    assign left   = cx - $signed({2'b00, w[COORD_W-1:1]});
    assign right  = cx + $signed({2'b00, w[COORD_W-1:1]});
    assign top    = cy - $signed({2'b00, h[COORD_W-1:1]});
    assign bottom = cy + $signed({2'b00, h[COORD_W-1:1]});

    assign pix_hit[i] = (px >= left) && (px < right) && (py >= top) && (py < bottom);

    assign rel_x = px - left;
    assign rel_y = py - top;
    assign rom_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(rel_y) * ADDR_W'(w) + ADDR_W'(rel_x);

    if (i == 0) begin : g_player
      assign kill_set[i] = 1'b0;
    end else begin : g_target
      assign kill_set[i] = attack && spr_en[0] && spr_en[i] &&
                           (hx >= left) && (hx < right) && (hy >= top) && (hy < bottom);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hit_s1   <= '0;
      en_s1    <= '0;
      valid_s1 <= 1'b0;
    end else begin
      hit_s1   <= pix_hit;
      en_s1    <= spr_en;
      valid_s1 <= 1'b1;
    end
  end

`ifdef COMPOSITOR_GRADIENT_EN
  logic [6:0] drawx_s1;

  always_ff @(posedge Clk) begin
    if (Reset) drawx_s1 <= '0;
    else       drawx_s1 <= DrawX[9:3];
  end

  assign bg_rgb = {8'h3F, 8'h00, 8'h7F - {1'b0, drawx_s1}};
`else
  assign bg_rgb = BG_RGB;
`endif

  // Scan from the back so the lowest-index opaque layer is written last and wins.
  always_comb begin
    pix_rgb = bg_rgb;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      opaque[i] = hit_s1[i] && en_s1[i] && (rom_rgb[i*24 +: 24] != KEY_RGB) && !killed[i];
      if (opaque[i]) pix_rgb = rom_rgb[i*24 +: 24];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) {VGA_R, VGA_G, VGA_B} <= '0;
    else if (valid_s1) {VGA_R, VGA_G, VGA_B} <= pix_rgb;
    else {VGA_R, VGA_G, VGA_B} <= '0;
  end

  assign rise = kill_set & ~killed;

  always_comb begin
    cap_en = 1'b0;
    cap_x  = death_x;
    cap_y  = death_y;
    for (int i = NUM_SPRITES - 1; i >= 1; i--) begin
      if (rise[i]) begin
        cap_en = 1'b1;
        cap_x  = spr_x[i*COORD_W +: COORD_W];
        cap_y  = spr_y[i*COORD_W +: COORD_W];
      end
    end
  end

  // Set dominates clear; the player's own flag is forced low.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      killed  <= '0;
      death_x <= '0;
      death_y <= '0;
    end else begin
      killed <= ((killed & ~clear_kill) | kill_set) & {{(NUM_SPRITES-1){1'b1}}, 1'b0};
      if (cap_en) begin
        death_x <= cap_x;
        death_y <= cap_y;
      end
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// tb/tb_sprite_compositor.sv - directed table-driven bench for sprite_compositor
module tb_sprite_compositor;

  localparam int N  = 4;
  localparam int CW = 10;
  localparam int AW = 14;
  localparam logic [23:0] KEY = 24'h800080;

  logic            Clk = 1'b0;
  logic            Reset;
  logic [CW-1:0]   DrawX, DrawY;
  logic [N*CW-1:0] spr_x, spr_y, spr_w, spr_h;
  logic [N-1:0]    spr_en;
  logic [N*AW-1:0] rom_addr;
  logic [N*24-1:0] rom_rgb;
  logic            facing_left, attack;
  logic [N-1:0]    clear_kill;
  logic [7:0]      VGA_R, VGA_G, VGA_B;
  logic [N-1:0]    killed;
  logic [CW-1:0]   death_x, death_y;

  int tests = 0;
  int fails = 0;

  sprite_compositor dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .spr_x(spr_x), .spr_y(spr_y), .spr_w(spr_w), .spr_h(spr_h), .spr_en(spr_en),
    .rom_addr(rom_addr), .rom_rgb(rom_rgb), .facing_left(facing_left), .attack(attack),
    .clear_kill(clear_kill), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .killed(killed), .death_x(death_x), .death_y(death_y)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          dx;
    int          dy;
    logic [23:0] rgb0;
    logic [23:0] rgb1;
    logic        use_bg;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [23:0] bg_exp(input int dx);
`ifdef COMPOSITOR_GRADIENT_EN
    logic [9:0] d;
    d = dx[9:0];
    return {8'h3F, 8'h00, 8'h7F - {1'b0, d[9:3]}};
`else
    return 24'h3F007F;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_spr(input int i, input int x, input int y, input int w, input int h);
    spr_x[i*CW +: CW] = CW'(x);
    spr_y[i*CW +: CW] = CW'(y);
    spr_w[i*CW +: CW] = CW'(w);
    spr_h[i*CW +: CW] = CW'(h);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Pixel presented now, palette data one cycle later, colour checked two cycles later.
  task automatic show(input string name, input int dx, input int dy,
                      input logic [N*24-1:0] rgb, input logic [23:0] exp);
    DrawX = CW'(dx);
    DrawY = CW'(dy);
    step();
    rom_rgb = rgb;
    step();
    chk(name, {VGA_R, VGA_G, VGA_B}, exp);
  endtask

  initial begin
    vecs[0] = '{100, 100, 24'hFF0000, 24'h00FF00, 1'b0, 24'hFF0000};
    vecs[1] = '{100, 100, KEY,        24'h00FF00, 1'b0, 24'h00FF00};
    vecs[2] = '{100, 100, 24'h0000FF, 24'h00FF00, 1'b0, 24'h0000FF};
    vecs[3] = '{125, 100, 24'hFF0000, 24'h00FF00, 1'b0, 24'h00FF00};
    vecs[4] = '{ 85, 100, KEY,        24'h00FF00, 1'b1, 24'h000000};
    vecs[5] = '{130, 100, 24'hFF0000, 24'h00FF00, 1'b1, 24'h000000};
    vecs[6] = '{ 80,  70, 24'h123456, 24'h00FF00, 1'b0, 24'h123456};
    vecs[7] = '{119, 129, 24'hABCDEF, 24'h00FF00, 1'b0, 24'hABCDEF};
    vecs[8] = '{100, 130, 24'hFF0000, 24'h00FF00, 1'b1, 24'h000000};
    vecs[9] = '{ 80, 300, 24'hFF0000, 24'h00FF00, 1'b1, 24'h000000};

    Reset = 1'b1;
    DrawX = '0; DrawY = '0;
    spr_x = '0; spr_y = '0; spr_w = '0; spr_h = '0; spr_en = '0;
    rom_rgb = '0; facing_left = 1'b0; attack = 1'b0; clear_kill = '0;
    step();
    step();
    chk("reset_vga", {VGA_R, VGA_G, VGA_B}, 24'h0);
    chk("reset_killed", killed, 4'b0000);
    chk("reset_death", {death_x, death_y}, 20'h0);
    Reset = 1'b0;

    set_spr(0, 100, 100, 40, 60);
    set_spr(1, 110, 100, 40, 60);
    spr_en = 4'b0011;
    step();

    DrawX = 10'd100; DrawY = 10'd100; #1;
    chk("addr0_center", rom_addr[0 +: AW], 14'd1220);
    DrawX = 10'd80; DrawY = 10'd70; #1;
    chk("addr0_corner", rom_addr[0 +: AW], 14'd0);
    DrawX = 10'd119; DrawY = 10'd129; #1;
    chk("addr0_far", rom_addr[0 +: AW], 14'd2399);

    for (int k = 0; k < 10; k++) begin
      show($sformatf("vec%0d", k), vecs[k].dx, vecs[k].dy,
           {48'h0, vecs[k].rgb1, vecs[k].rgb0},
           vecs[k].use_bg ? bg_exp(vecs[k].dx) : vecs[k].exp);
    end

    // Left edge below zero must not wrap around to the right of the screen.
    set_spr(2, 5, 100, 40, 60);
    spr_en = 4'b0100;
    DrawX = 10'd0; DrawY = 10'd100; #1;
    chk("addr2_neg_left", rom_addr[2*AW +: AW], 14'd1215);
    show("nowrap_630", 630, 100, {24'h0, 24'hC0FFEE, 48'h0}, bg_exp(630));
    show("wrap_hit_0", 0, 100, {24'h0, 24'hC0FFEE, 48'h0}, 24'hC0FFEE);

    set_spr(0, 200, 100, 20, 20);
    set_spr(1, 220, 100, 30, 64);
    spr_en = 4'b0011;
    facing_left = 1'b0;
    attack = 1'b1;
    step();
    attack = 1'b0;
    chk("kill1", killed, 4'b0010);
    chk("death_xy1", {death_x, death_y}, {10'd220, 10'd100});
    show("killed_hidden", 230, 100, {48'h0, 24'h00FF00, 24'hFF0000}, bg_exp(230));

    clear_kill = 4'b0010;
    attack = 1'b1;
    step();
    attack = 1'b0;
    chk("set_beats_clear", killed, 4'b0010);
    step();
    clear_kill = 4'b0000;
    chk("clear_alone", killed, 4'b0000);

    facing_left = 1'b1;
    attack = 1'b1;
    step();
    attack = 1'b0;
    chk("face_left_miss", killed, 4'b0000);

    facing_left = 1'b0;
    attack = 1'b1;
    step();
    chk("rekill1", killed, 4'b0010);
    set_spr(2, 215, 100, 30, 64);
    set_spr(3, 225, 110, 30, 64);
    spr_en = 4'b1101;
    step();
    attack = 1'b0;
    chk("multi_kill_hold", killed, 4'b1110);
    chk("death_lowest", {death_x, death_y}, {10'd215, 10'd100});

    clear_kill = 4'b0001;
    step();
    chk("clear_bit0_ignored", killed, 4'b1110);
    clear_kill = 4'b0110;
    step();
    clear_kill = 4'b0000;
    chk("clear_multi", killed, 4'b1000);

    set_spr(0, 100, 100, 40, 60);
    spr_en = 4'b0001;
    DrawX = 10'd100; DrawY = 10'd100;
    rom_rgb = {72'h0, 24'hFF0000};
    step();
    step();
    chk("pre_reset_vga", {VGA_R, VGA_G, VGA_B}, 24'hFF0000);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("midreset_vga", {VGA_R, VGA_G, VGA_B}, 24'h0);
    chk("midreset_killed", killed, 4'b0000);
    chk("midreset_death", {death_x, death_y}, 20'h0);
    step();
    chk("post_reset_blank", {VGA_R, VGA_G, VGA_B}, 24'h0);
    step();
    chk("post_reset_resume", {VGA_R, VGA_G, VGA_B}, 24'hFF0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
